// File: rtl/button_event_pkg.sv
// Shared types and default timing constants for the button event decoder.
package button_event_pkg;

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } state_t;

    localparam int LONG_CYCLES_DEF   = 16;
    localparam int REPEAT_CYCLES_DEF = 4;

    function automatic logic is_held(input state_t st);
        return (st == PRESSED) || (st == LONG);
    endfunction

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long/auto-repeat strobes.
// Auto-repeat is compiled in only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic REPEAT_EN = 1'b1;
`else
    localparam logic REPEAT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   hold_cnt_r;
    logic [CNT_W-1:0]   hold_cnt_s;
    logic               press_s;
    logic               release_s;
    logic               long_s;
    logic               repeat_s;

    // Next-state, hold counter and pulse decode; release always beats long/repeat.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        press_s    = 1'b0;
        release_s  = 1'b0;
        long_s     = 1'b0;
        repeat_s   = 1'b0;
        case (state_r)
            LOCKOUT: begin
                hold_cnt_s = '0;
                if (!button_in) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOCKOUT;
                end
            end
            IDLE: begin
                hold_cnt_s = '0;
                if (button_in) begin
                    state_s = PRESSED;
                    press_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESSED: begin
                if (!button_in) begin
                    state_s    = IDLE;
                    release_s  = 1'b1;
                    hold_cnt_s = '0;
                end else if (hold_cnt_r == LONG_LAST) begin
                    state_s    = LONG;
                    long_s     = 1'b1;
                    hold_cnt_s = '0;
                end else begin
                    hold_cnt_s = hold_cnt_r + CNT_W'(1);
                end
            end
            LONG: begin
                if (!button_in) begin
                    state_s    = IDLE;
                    release_s  = 1'b1;
                    hold_cnt_s = '0;
                end else if (!REPEAT_EN) begin
                    hold_cnt_s = '0;
                end else if (hold_cnt_r == REPEAT_LAST) begin
                    repeat_s   = 1'b1;
                    hold_cnt_s = '0;
                end else begin
                    hold_cnt_s = hold_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s    = LOCKOUT;
                hold_cnt_s = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset parks in LOCKOUT with no strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= LOCKOUT;
            hold_cnt_r    <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state_r       <= state_s;
            hold_cnt_r    <= hold_cnt_s;
            press_pulse   <= press_s;
            release_pulse <= release_s;
            long_pulse    <= long_s;
            repeat_pulse  <= repeat_s;
            held          <= is_held(state_s);
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: a vector table plus multi-cycle hold sequences.
module tb_button_event;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
    localparam int HOLD_N = 30;
`else
    localparam bit REP_EN = 1'b0;
    localparam int HOLD_N = 40;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_in = 1'b0;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    int errors = 0;
    int checks = 0;

    button_event dut (
        .clk           (clk),
        .rst           (rst),
        .button_in     (button_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    // exp bits: {press, release, long, repeat, held}
    typedef struct {
        logic       r;
        logic       b;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [24];

    task automatic cyc(input logic r, input logic b, input logic [4:0] exp, input string name);
        logic [4:0] act;
        rst       = r;
        button_in = b;
        @(posedge clk);
        #1;
        act = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (press,release,long,repeat,held)", name, act, exp);
        end
    endtask

    initial begin
        // short press, reset held high, reset in PRESSED
        vecs[0]  = '{1'b1, 1'b0, 5'b00000};
        vecs[1]  = '{1'b1, 1'b0, 5'b00000};
        vecs[2]  = '{1'b0, 1'b0, 5'b00000};
        vecs[3]  = '{1'b0, 1'b1, 5'b10001};
        vecs[4]  = '{1'b0, 1'b1, 5'b00001};
        vecs[5]  = '{1'b0, 1'b1, 5'b00001};
        vecs[6]  = '{1'b0, 1'b1, 5'b00001};
        vecs[7]  = '{1'b0, 1'b1, 5'b00001};
        vecs[8]  = '{1'b0, 1'b1, 5'b00001};
        vecs[9]  = '{1'b0, 1'b0, 5'b01000};
        vecs[10] = '{1'b0, 1'b0, 5'b00000};
        vecs[11] = '{1'b1, 1'b1, 5'b00000};
        vecs[12] = '{1'b1, 1'b1, 5'b00000};
        vecs[13] = '{1'b0, 1'b1, 5'b00000};
        vecs[14] = '{1'b0, 1'b1, 5'b00000};
        vecs[15] = '{1'b0, 1'b1, 5'b00000};
        vecs[16] = '{1'b0, 1'b0, 5'b00000};
        vecs[17] = '{1'b0, 1'b1, 5'b10001};
        vecs[18] = '{1'b1, 1'b1, 5'b00000};
        vecs[19] = '{1'b0, 1'b1, 5'b00000};
        vecs[20] = '{1'b0, 1'b0, 5'b00000};
        vecs[21] = '{1'b0, 1'b1, 5'b10001};
        vecs[22] = '{1'b0, 1'b0, 5'b01000};
        vecs[23] = '{1'b0, 1'b0, 5'b00000};

        for (int i = 0; i < 24; i++) begin
            cyc(vecs[i].r, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // long hold: long at press+16, repeats every 4 after it when enabled
        cyc(1'b0, 1'b1, 5'b10001, "s2_press");
        for (int i = 1; i <= HOLD_N; i++) begin
            logic l, rp;
            l  = (i == 16);
            rp = REP_EN && (i > 16) && (((i - 16) % 4) == 0);
            cyc(1'b0, 1'b1, {1'b0, 1'b0, l, rp, 1'b1}, $sformatf("s2_hold%0d", i));
        end
        cyc(1'b0, 1'b0, 5'b01000, "s2_release");
        cyc(1'b0, 1'b0, 5'b00000, "s2_idle");

        // button held through reset and 20 cycles beyond
        cyc(1'b1, 1'b1, 5'b00000, "s3_rst0");
        cyc(1'b1, 1'b1, 5'b00000, "s3_rst1");
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 5'b00000, $sformatf("s3_lock%0d", i));
        end
        cyc(1'b0, 1'b0, 5'b00000, "s3_low");
        cyc(1'b0, 1'b1, 5'b10001, "s3_press");
        cyc(1'b0, 1'b0, 5'b01000, "s3_release");

        // release on the long edge: release only
        cyc(1'b0, 1'b1, 5'b10001, "s4_press");
        for (int i = 1; i <= 15; i++) begin
            cyc(1'b0, 1'b1, 5'b00001, $sformatf("s4_hold%0d", i));
        end
        cyc(1'b0, 1'b0, 5'b01000, "s4_release_not_long");
        cyc(1'b0, 1'b0, 5'b00000, "s4_idle");

        // release on the first repeat edge: release only
        cyc(1'b0, 1'b1, 5'b10001, "s4b_press");
        for (int i = 1; i <= 19; i++) begin
            cyc(1'b0, 1'b1, {1'b0, 1'b0, (i == 16), 1'b0, 1'b1}, $sformatf("s4b_hold%0d", i));
        end
        cyc(1'b0, 1'b0, 5'b01000, "s4b_release_not_repeat");

        // reset while in LONG: no release strobe, then normal press
        cyc(1'b0, 1'b1, 5'b10001, "s5_press");
        for (int i = 1; i <= 17; i++) begin
            cyc(1'b0, 1'b1, {1'b0, 1'b0, (i == 16), 1'b0, 1'b1}, $sformatf("s5_hold%0d", i));
        end
        cyc(1'b1, 1'b1, 5'b00000, "s5_rst_in_long");
        cyc(1'b0, 1'b0, 5'b00000, "s5_low");
        cyc(1'b0, 1'b1, 5'b10001, "s5_press2");
        cyc(1'b0, 1'b0, 5'b01000, "s5_release2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_CYCLES, default 16, cycles of continuous hold after press_pulse before long_pulse; legal range 2 to 2^CNT_W-1.
REQ-002 Parameter REPEAT_CYCLES, default 4, cycles between auto-repeat pulses; legal range 1 to 2^CNT_W-1.
REQ-003 Parameter CNT_W, default 8, width of the hold counter.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 button_in  input  1  debounced, clk-synchronous button level from debounce; 1 = pressed.
REQ-007 press_pulse  output  1  one-cycle strobe on press.
REQ-008 release_pulse  output  1  one-cycle strobe on release.
REQ-009 long_pulse  output  1  one-cycle strobe when the hold reaches LONG_CYCLES.
REQ-010 repeat_pulse  output  1  one-cycle auto-repeat strobe during a long hold.
REQ-011 held  output  1  level; 1 while state is PRESSED or LONG.

Function
REQ-012 The block SHALL implement the states LOCKOUT, IDLE, PRESSED and LONG, and all outputs SHALL be registered.
REQ-013 LOCKOUT: on a clock edge that samples button_in=0, go to IDLE; no pulses are issued from LOCKOUT.
REQ-014 IDLE: on a clock edge that samples button_in=1, go to PRESSED, assert press_pulse for exactly the following cycle, and clear hold_cnt to 0.
REQ-015 PRESSED with button_in=1: hold_cnt increments by 1 per cycle; on the edge where hold_cnt = LONG_CYCLES-1, go to LONG, assert long_pulse for one cycle, and clear hold_cnt. long_pulse is therefore LONG_CYCLES cycles after press_pulse.
REQ-016 PRESSED or LONG with button_in=0: go to IDLE, assert release_pulse for one cycle, clear hold_cnt, and drop held on the same edge.
REQ-017 Release on the same edge on which long or repeat would fire: release wins; only release_pulse is asserted.
REQ-018 At most one of the four pulse outputs SHALL be high in any cycle.
REQ-019 The hold counter SHALL never wrap outside the behaviour defined in REQ-015, REQ-024 and REQ-025.

Reset
REQ-020 While rst=1 at a clock edge, the next state SHALL be LOCKOUT, hold_cnt SHALL be 0, and all outputs SHALL be 0 in the following cycle, regardless of state or button_in.
REQ-021 Reset asserted mid-press (PRESSED or LONG) SHALL NOT produce release_pulse.
REQ-022 A button still held at reset release SHALL generate no press_pulse until it is first sampled low.

Configuration
REQ-023 The macro BUTTON_EVENT_REPEAT_EN SHALL compile the auto-repeat feature in or out.
REQ-024 With BUTTON_EVENT_REPEAT_EN defined, in LONG with button_in=1:
- hold_cnt increments each cycle;
- on the edge where hold_cnt = REPEAT_CYCLES-1, repeat_pulse is asserted for one cycle and hold_cnt clears to 0;
- repeats therefore fall at LONG_CYCLES + k*REPEAT_CYCLES cycles after press_pulse, for k >= 1.
REQ-025 Without BUTTON_EVENT_REPEAT_EN:
- repeat_pulse is a constant 0;
- hold_cnt holds at 0 in LONG;
- LONG is left only by release or reset.

Structure
REQ-026 The package button_event_pkg SHALL hold the state enumeration (LOCKOUT, IDLE, PRESSED, LONG) and the default constants LONG_CYCLES_DEF=16 and REPEAT_CYCLES_DEF=4.
REQ-027 The block SHALL be a single module with no sub-module; the hold counter and the FSM are inline, with one next-state block and one registered output block.

Verification
REQ-028 Scenario 1, short press: rst held 2 cycles with button_in=0, then button_in=1 at edge k -> press_pulse high only in cycle k+1 and held=1. Drop button_in after 5 cycles -> release_pulse for one cycle; long_pulse never asserted.
REQ-029 Scenario 2, long hold with repeat (defaults, BUTTON_EVENT_REPEAT_EN defined): hold 30 cycles -> long_pulse at press+16 and repeat_pulse at press+20, +24 and +28. On release -> one release_pulse, and held=0 on the next edge.
REQ-030 Scenario 3, held through reset: button_in=1 during and after reset for 20 cycles -> no pulses and held=0. Then button_in=0 for 1 cycle followed by 1 -> press_pulse asserted.
REQ-031 Scenario 4, simultaneous event: button_in drops on exactly the edge where long_pulse would fire (press+16) -> release_pulse only; long_pulse stays 0.
REQ-032 Scenario 5, reset in LONG: rst pulsed at press+18 -> all outputs 0 next cycle and no release_pulse. Then button_in=0 followed by 1 -> normal press_pulse.
REQ-033 Scenario 6, repeat compiled out: build without BUTTON_EVENT_REPEAT_EN and hold 40 cycles -> exactly one long_pulse at press+16; repeat_pulse constant 0.
